// File: rtl/rst_cipher_ctrl.sv
// Sequencer for one rst_cipher: installs and validates a 12-char key, streams plaintext
// into the fixed-latency cipher and buffers ciphertext pairs for a back-pressured sink.
`timescale 1ns/1ps
module rst_cipher_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter bit MSG_RESTART = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [95:0] key_in,
    input  logic        key_load,
    output logic        key_load_ready,
    output logic        key_ok,
    output logic        key_err,
    input  logic        ptxt_in_valid,
    output logic        ptxt_in_ready,
    input  logic [7:0]  ptxt_in_char,
    input  logic        ptxt_in_last,
    output logic        ctxt_out_valid,
    input  logic        ctxt_out_ready,
    output logic [15:0] ctxt_out_data,
    output logic        msg_done,
    output logic [7:0]  drop_cnt,
    output logic        cph_rst_n,
    output logic [95:0] cph_key,
    output logic        cph_ptxt_valid,
    output logic [7:0]  cph_ptxt_char,
    input  logic [15:0] cph_ctxt_str,
    input  logic        cph_ctxt_ready,
    input  logic        cph_err_invalid_key,
    input  logic        cph_err_invalid_ptxt_char
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, KRST, KWAIT, KCHK, READY, STREAM, DRAIN} state_t;

    state_t        state_q, state_d;
    logic          key_ok_q, key_ok_d;
    logic          key_err_q, key_err_d;
    logic          msg_sent_q, msg_sent_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic          msg_done_q, msg_done_d;
    logic          cph_rst_n_q, cph_rst_n_d;
    logic [95:0]   key_q;
    logic          key_ld, accept;

    logic          vld_p1_q, vld_p2_q;
    logic [7:0]    char_p1_q;
    logic [1:0]    inflight;
    logic [CW:0]   occ;

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop;

    logic          unused_diag;
    assign unused_diag = cph_err_invalid_ptxt_char;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Credit: FIFO entries plus chars still in the two-cycle cipher path
    assign inflight = {1'b0, vld_p1_q} + {1'b0, vld_p2_q};
    assign occ      = {1'b0, cnt_q} + {{(CW-1){1'b0}}, inflight};
    assign push     = vld_p2_q && cph_ctxt_ready;
    assign pop      = ctxt_out_ready && (cnt_q != '0);

    always_comb begin
        state_d        = state_q;
        key_ok_d       = key_ok_q;
        key_err_d      = key_err_q;
        msg_sent_d     = msg_sent_q;
        drop_cnt_d     = drop_cnt_q;
        msg_done_d     = 1'b0;
        key_ld         = 1'b0;
        accept         = 1'b0;
        ptxt_in_ready  = 1'b0;
        key_load_ready = (state_q == IDLE) || (state_q == READY);

        if (vld_p2_q && !cph_ctxt_ready)
            drop_cnt_d = sat_inc8(drop_cnt_q);

        case (state_q)
            IDLE: begin
                if (key_load) begin
                    key_ld  = 1'b1;
                    state_d = KRST;
                end
            end
            KRST:  state_d = KWAIT;
            KWAIT: state_d = KCHK;
            KCHK: begin
                if (cph_err_invalid_key) begin
                    key_err_d = 1'b1;
                    key_ok_d  = 1'b0;
                    state_d   = IDLE;
                end else begin
                    key_ok_d   = 1'b1;
                    key_err_d  = 1'b0;
                    msg_sent_d = 1'b0;
                    state_d    = READY;
                end
            end
            READY: begin
                if (key_load) begin
                    key_ld  = 1'b1;
                    state_d = KRST;
                end else if (ptxt_in_valid) begin
                    // Re-install returns here with msg_sent cleared, then streams
                    if (MSG_RESTART && msg_sent_q) begin
                        state_d = KRST;
                    end else begin
                        state_d    = STREAM;
                        drop_cnt_d = 8'd0;
                    end
                end
            end
            STREAM: begin
                ptxt_in_ready = (occ < DEPTH_C);
                if (ptxt_in_valid && ptxt_in_ready) begin
                    accept = 1'b1;
                    if (ptxt_in_last)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight == 2'd0) begin
                    msg_done_d = 1'b1;
                    msg_sent_d = 1'b1;
                    state_d    = READY;
                end
            end
            default: state_d = IDLE;
        endcase

        cph_rst_n_d = !((state_d == IDLE) || (state_d == KRST));
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            key_ok_q    <= 1'b0;
            key_err_q   <= 1'b0;
            msg_sent_q  <= 1'b0;
            drop_cnt_q  <= 8'd0;
            msg_done_q  <= 1'b0;
            cph_rst_n_q <= 1'b0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            key_ok_q    <= key_ok_d;
            key_err_q   <= key_err_d;
            msg_sent_q  <= msg_sent_d;
            drop_cnt_q  <= drop_cnt_d;
            msg_done_q  <= msg_done_d;
            cph_rst_n_q <= cph_rst_n_d;
            // p1: char on cipher inputs; p2: cipher result due
            vld_p1_q    <= accept;
            vld_p2_q    <= vld_p1_q;
            cnt_q       <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (key_ld) key_q <= key_in;
        if (accept) char_p1_q <= ptxt_in_char;
        if (push)   mem_q[wr_ptr_q] <= cph_ctxt_str;
    end

    assign key_ok         = key_ok_q;
    assign key_err        = key_err_q;
    assign msg_done       = msg_done_q;
    assign drop_cnt       = drop_cnt_q;
    assign cph_rst_n      = cph_rst_n_q;
    assign cph_key        = key_q;
    assign cph_ptxt_valid = vld_p1_q;
    assign cph_ptxt_char  = char_p1_q;
    assign ctxt_out_valid = (cnt_q != '0);
    assign ctxt_out_data  = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_rst_cipher_ctrl.sv
// Directed bench for rst_cipher_ctrl: two instances (MSG_RESTART 1 and 0), each driving
// a behavioural stand-in for the rotating cipher with a fixed lookup of known pairs.
`timescale 1ns/1ps
module tb_rst_cipher_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic [95:0] key_in = '0;
    logic        key_load = 1'b0;
    logic [7:0]  p_char = 8'd0;
    logic        p_last = 1'b0;
    logic        vld_a = 1'b0, vld_b = 1'b0;
    logic        rdy_a = 1'b1, rdy_b = 1'b1;

    logic        a_klr, a_kok, a_kerr, a_in_rdy, a_out_vld, a_done, a_crst, a_cvld;
    logic [15:0] a_out_data;
    logic [7:0]  a_drop, a_cchar;
    logic [95:0] a_ckey;
    logic [15:0] a_cstr;
    logic        a_crdy, a_ckerr, a_cperr;
    logic [7:0]  rot_a;

    logic        b_klr, b_kok, b_kerr, b_in_rdy, b_out_vld, b_done, b_crst, b_cvld;
    logic [15:0] b_out_data;
    logic [7:0]  b_drop, b_cchar;
    logic [95:0] b_ckey;
    logic [15:0] b_cstr;
    logic        b_crdy, b_ckerr, b_cperr;
    logic [7:0]  rot_b;

    int n_chk = 0, n_bad = 0;
    int done_a = 0, done_b = 0;
    logic [15:0] q_a [$];
    logic [15:0] q_b [$];

    rst_cipher_ctrl #(.FIFO_DEPTH(4), .MSG_RESTART(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load),
        .key_load_ready(a_klr), .key_ok(a_kok), .key_err(a_kerr),
        .ptxt_in_valid(vld_a), .ptxt_in_ready(a_in_rdy), .ptxt_in_char(p_char),
        .ptxt_in_last(p_last), .ctxt_out_valid(a_out_vld), .ctxt_out_ready(rdy_a),
        .ctxt_out_data(a_out_data), .msg_done(a_done), .drop_cnt(a_drop),
        .cph_rst_n(a_crst), .cph_key(a_ckey), .cph_ptxt_valid(a_cvld),
        .cph_ptxt_char(a_cchar), .cph_ctxt_str(a_cstr), .cph_ctxt_ready(a_crdy),
        .cph_err_invalid_key(a_ckerr), .cph_err_invalid_ptxt_char(a_cperr));

    rst_cipher_ctrl #(.FIFO_DEPTH(4), .MSG_RESTART(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load),
        .key_load_ready(b_klr), .key_ok(b_kok), .key_err(b_kerr),
        .ptxt_in_valid(vld_b), .ptxt_in_ready(b_in_rdy), .ptxt_in_char(p_char),
        .ptxt_in_last(p_last), .ctxt_out_valid(b_out_vld), .ctxt_out_ready(rdy_b),
        .ctxt_out_data(b_out_data), .msg_done(b_done), .drop_cnt(b_drop),
        .cph_rst_n(b_crst), .cph_key(b_ckey), .cph_ptxt_valid(b_cvld),
        .cph_ptxt_char(b_cchar), .cph_ctxt_str(b_cstr), .cph_ctxt_ready(b_crdy),
        .cph_err_invalid_key(b_ckerr), .cph_err_invalid_ptxt_char(b_cperr));

    function automatic bit is_letter(input logic [7:0] c);
        return ((c >= "A") && (c <= "Z")) || ((c >= "a") && (c <= "z"));
    endfunction

    function automatic bit key_valid(input logic [95:0] k);
        for (int i = 0; i < 12; i++)
            if (!is_letter(k[8*i +: 8])) return 1'b0;
        return 1'b1;
    endfunction

    // Known pairs for key "ABCDEFGHIJKL"; other chars map to {char, '0'+rotation}
    function automatic logic [15:0] cipher_out(input logic [7:0] c, input logic [7:0] r);
        case ({c, r})
            {"H", 8'd0}: return "KL";
            {"H", 8'd1}: return "AB";
            {"e", 8'd1}: return "GJ";
            {"l", 8'd2}: return "GJ";
            {"l", 8'd3}: return "ED";
            {"o", 8'd4}: return "EF";
            {"a", 8'd0}: return "AB";
            {"b", 8'd1}: return "GB";
            default:     return {c, 8'h30 + r};
        endcase
    endfunction

    always @(posedge clk) begin
        if (!a_crst) begin
            rot_a <= 8'd0; a_crdy <= 1'b0; a_ckerr <= 1'b0; a_cperr <= 1'b0;
        end else begin
            a_ckerr <= !key_valid(a_ckey);
            a_crdy  <= a_cvld && is_letter(a_cchar);
            a_cperr <= a_cvld && !is_letter(a_cchar);
            if (a_cvld && is_letter(a_cchar)) begin
                a_cstr <= cipher_out(a_cchar, rot_a);
                rot_a  <= rot_a + 8'd1;
            end
        end
    end

    always @(posedge clk) begin
        if (!b_crst) begin
            rot_b <= 8'd0; b_crdy <= 1'b0; b_ckerr <= 1'b0; b_cperr <= 1'b0;
        end else begin
            b_ckerr <= !key_valid(b_ckey);
            b_crdy  <= b_cvld && is_letter(b_cchar);
            b_cperr <= b_cvld && !is_letter(b_cchar);
            if (b_cvld && is_letter(b_cchar)) begin
                b_cstr <= cipher_out(b_cchar, rot_b);
                rot_b  <= rot_b + 8'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (a_out_vld && rdy_a) q_a.push_back(a_out_data);
        if (b_out_vld && rdy_b) q_b.push_back(b_out_data);
        if (a_done) done_a++;
        if (b_done) done_b++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load_key(input logic [95:0] k);
        bit ok = 1'b0;
        key_in = k; key_load = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_klr) begin ok = 1'b1; break; end
        end
        tick();
        key_load = 1'b0;
        chk("key_accept", ok, 1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_klr) begin ok = 1'b1; break; end
        end
        chk("key_install", ok, 1);
        tick();
    endtask

    task automatic send(input int which, input logic [7:0] c, input logic l);
        bit ok = 1'b0;
        p_char = c; p_last = l;
        if (which == 0) vld_a = 1'b1; else vld_b = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((which == 0) ? a_in_rdy : b_in_rdy) begin ok = 1'b1; break; end
        end
        tick();
        vld_a = 1'b0; vld_b = 1'b0; p_last = 1'b0;
        chk($sformatf("send_%s", string'(c)), ok, 1);
    endtask

    task automatic send_str(input int which, input string s, input bit last_at_end);
        for (int i = 0; i < s.len(); i++)
            send(which, s[i], last_at_end && (i == s.len() - 1));
    endtask

    task automatic wait_done(input int which, input int base, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (((which == 0) ? done_a : done_b) > base) begin ok = 1'b1; break; end
        end
        chk(tag, ok, 1);
        repeat (6) tick();
    endtask

    task automatic check_seq(input int which, input int start, input string tag, input string e);
        logic [15:0] got [$];
        int n;
        if (which == 0) got = q_a; else got = q_b;
        n = e.len() / 2;
        chk({tag, "_len"}, got.size() - start, n);
        for (int i = 0; i < n; i++)
            if (start + i < got.size())
                chk($sformatf("%s_%0d", tag, i), got[start + i], {e[2*i], e[2*i+1]});
    endtask

    task automatic run_hello(input string tag);
        int base = done_a;
        int st = q_a.size();
        send_str(0, "Hello", 1'b1);
        wait_done(0, base, {tag, "_done_seen"});
        check_seq(0, st, tag, "KLGJGJEDEF");
        chk({tag, "_done_cnt"}, done_a, base + 1);
        chk({tag, "_drop"}, a_drop, 0);
    endtask

    initial begin
        int base, st, st_b;
        bit seen;
        repeat (3) tick();
        // Reset values
        chk("rst_kok", a_kok, 0);
        chk("rst_kerr", a_kerr, 0);
        chk("rst_crst", a_crst, 0);
        chk("rst_outvld", a_out_vld, 0);
        chk("rst_done", a_done, 0);
        chk("rst_drop", a_drop, 0);
        chk("rst_cvld", a_cvld, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_klr", a_klr, 1);
        chk("idle_inrdy", a_in_rdy, 0);

        // T2: invalid key
        load_key("ABC?*-.HIJKL");
        chk("t2_kerr", a_kerr, 1);
        chk("t2_kok", a_kok, 0);
        chk("t2_idle", a_klr, 1);
        vld_a = 1'b1; p_char = "a"; seen = 1'b0;
        repeat (6) begin @(negedge clk); if (a_in_rdy) seen = 1'b1; end
        tick();
        vld_a = 1'b0;
        chk("t2_inrdy", seen, 0);

        // T1
        load_key("ABCDEFGHIJKL");
        chk("t1_kok", a_kok, 1);
        chk("t1_kerr", a_kerr, 0);
        run_hello("t1");

        // T3: invalid char dropped
        base = done_a; st = q_a.size();
        send(0, "a", 1'b0); send(0, "-", 1'b0); send(0, "b", 1'b1);
        wait_done(0, base, "t3_done_seen");
        check_seq(0, st, "t3", "ABGB");
        chk("t3_drop", a_drop, 1);
        chk("t3_done_cnt", done_a, base + 1);

        // T4: stalled sink limits acceptance to FIFO depth
        rdy_a = 1'b0; base = done_a; st = q_a.size();
        send_str(0, "abcd", 1'b0);
        vld_a = 1'b1; p_char = "e"; seen = 1'b0;
        repeat (6) begin @(negedge clk); if (a_in_rdy) seen = 1'b1; end
        chk("t4_blocked", seen, 0);
        chk("t4_head_vld", a_out_vld, 1);
        chk("t4_head", a_out_data, "AB");
        tick();
        vld_a = 1'b0; rdy_a = 1'b1;
        send_str(0, "efghij", 1'b1);
        wait_done(0, base, "t4_done_seen");
        check_seq(0, st, "t4", "ABGBc2d3e4f5g6h7i8j9");

        // T5: restart vs continuing rotation
        load_key("ABCDEFGHIJKL");
        st = q_a.size(); st_b = q_b.size();
        base = done_a; send(0, "H", 1'b1); wait_done(0, base, "t5a_d1");
        base = done_a; send(0, "H", 1'b1); wait_done(0, base, "t5a_d2");
        check_seq(0, st, "t5a", "KLKL");
        base = done_b; send(1, "H", 1'b1); wait_done(1, base, "t5b_d1");
        base = done_b; send(1, "H", 1'b1); wait_done(1, base, "t5b_d2");
        check_seq(1, st_b, "t5b", "KLAB");

        // T6: async reset mid-stream
        rdy_a = 1'b0;
        send(0, "a", 1'b0); send(0, "b", 1'b0);
        repeat (4) tick();
        chk("t6_pre_vld", a_out_vld, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_outvld", a_out_vld, 0);
        chk("t6_kok", a_kok, 0);
        chk("t6_crst", a_crst, 0);
        chk("t6_klr", a_klr, 1);
        tick(); tick();
        rst_n = 1'b1; rdy_a = 1'b1;
        tick();
        load_key("ABCDEFGHIJKL");
        run_hello("t6");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish required finish within time limit");
        $fatal(1);
    end

endmodule
